// File: rtl/bsram_pkg.sv
//------------------------------------------------------------------------------
// Module      : bsram_pkg
// Description : Shared constants and types for the parametrised single-port
//               block-RAM model (write/read mode codes, clear FSM states).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bsram_pkg;

  // First-stage behaviour on a write access
  localparam int WM_NOCHANGE   = 0;  // first stage untouched, no DOV
  localparam int WM_WRITETHRU  = 1;  // first stage gets the merged new word
  localparam int WM_READBEFORE = 2;  // first stage gets the pre-write word

  // Output stage arrangement
  localparam int RM_BYPASS     = 0;  // DO straight from the first stage
  localparam int RM_PIPELINE   = 1;  // extra free-running output register

  // Clear sequencer states
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } bsram_state_e;

  // Word-index width; a one-word array still needs a one-bit index
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsram_clr_seq.sv
//------------------------------------------------------------------------------
// Module      : bsram_clr_seq
// Description : Clear sequencer. Sweeps a zero-write pointer across the whole
//               array after reset release or on a CLR request and reports BUSY
//               while the sweep runs. Provides an override write port that the
//               array gives priority over user accesses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsram_clr_seq #(
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_clr,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [IDX_W-1:0] o_clr_ptr
);

  import bsram_pkg::*;

  localparam logic [IDX_W-1:0] c_last = IDX_W'(DEPTH - 1);

  bsram_state_e     r_state;
  logic [IDX_W-1:0] r_ptr;

  // Sweep FSM: a CLR request always (re)starts at word 0, from either state
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (i_clr) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_ptr == c_last) begin
        r_state <= ST_IDLE;
        r_ptr   <= '0;
      end else begin
        r_ptr   <= r_ptr + 1'b1;
      end
    end
  end

  // The restart cycle itself writes nothing; the sweep begins on the next edge
  assign o_busy    = (r_state == ST_CLEAR);
  assign o_clr_we  = (r_state == ST_CLEAR) && !i_clr;
  assign o_clr_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/bsram_sp_gen.sv
//------------------------------------------------------------------------------
// Module      : bsram_sp_gen
// Description : Parametrised single-port block-RAM model with per-lane byte
//               enables, three write modes, optional output pipeline register,
//               read-valid strobe and a hardware clear sweep.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsram_sp_gen #(
  parameter int DATA_W     = 36,
  parameter int LANE_W     = 9,
  parameter int DEPTH      = 512,
  parameter int AD_W       = 14,
  parameter int AD_LSB     = 5,
  parameter int WRITE_MODE = 0,
  parameter int READ_MODE  = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CE,
  input  logic                       WRE,
  input  logic [AD_W-1:0]            AD,
  input  logic [DATA_W-1:0]          DI,
  input  logic [DATA_W/LANE_W-1:0]   BE,
  input  logic                       CLR,
  output logic [DATA_W-1:0]          DO,
  output logic                       DOV,
  output logic                       BUSY
);

  import bsram_pkg::*;

  localparam int                 NLANE   = DATA_W / LANE_W;
  localparam int                 IDX_W   = idx_width(DEPTH);
  localparam logic [IDX_W:0]     c_depth = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_busy;
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_ptr;
  logic              w_access;
  logic              w_wr;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic              w_s1_load;
  logic [DATA_W-1:0] w_s1_next;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_vld;
  logic              w_unused_ad;

  // Only the index field of AD is decoded; the remaining bits are don't-care
  assign w_unused_ad = ^AD;

  assign w_idx      = AD[AD_LSB +: IDX_W];
  assign w_in_range = ({1'b0, w_idx} < c_depth);

  bsram_clr_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clr_seq (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_clr     (CLR),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_ptr (w_clr_ptr)
  );

  assign BUSY = w_busy;

  // A CLR request in the same cycle as an access wins and the access is lost
  assign w_access = CE && !w_busy && !CLR;
  assign w_wr     = w_access && WRE;

  // Out-of-range indices read as zero and never touch the array
  assign w_old = w_in_range ? r_mem[w_idx] : '0;

  generate
    for (genvar l = 0; l < NLANE; l++) begin : g_lane
      assign w_merged[l*LANE_W +: LANE_W] =
        BE[l] ? DI[l*LANE_W +: LANE_W] : w_old[l*LANE_W +: LANE_W];
    end
  endgenerate

  // Array write port: the clear sweep has priority (the two never overlap
  // in practice since user accesses are blocked while BUSY)
  always_ff @(posedge CLK) begin
    if (w_clr_we) begin
      r_mem[w_clr_ptr] <= '0;
    end else if (w_wr && w_in_range) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // First-stage source selection by access type and write mode
  always_comb begin
    w_s1_load = 1'b0;
    w_s1_next = w_old;
    if (w_access) begin
      if (!WRE) begin
        w_s1_load = 1'b1;
        w_s1_next = w_old;
      end else if (WRITE_MODE == WM_WRITETHRU) begin
        w_s1_load = 1'b1;
        w_s1_next = w_in_range ? w_merged : '0;
      end else if (WRITE_MODE == WM_READBEFORE) begin
        w_s1_load = 1'b1;
        w_s1_next = w_old;
      end
    end
  end

  // First stage: data holds between producing accesses, valid is a pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1_data <= '0;
      r_s1_vld  <= 1'b0;
    end else begin
      r_s1_vld <= w_s1_load;
      if (w_s1_load) begin
        r_s1_data <= w_s1_next;
      end
    end
  end

  generate
    if (READ_MODE == RM_PIPELINE) begin : g_pipe
      logic [DATA_W-1:0] r_s2_data;
      logic              r_s2_vld;

      // Output register follows the first stage every cycle, independent of CE
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          r_s2_data <= '0;
          r_s2_vld  <= 1'b0;
        end else begin
          r_s2_data <= r_s1_data;
          r_s2_vld  <= r_s1_vld;
        end
      end

      assign DO  = r_s2_data;
      assign DOV = r_s2_vld;
    end else begin : g_bypass
      assign DO  = r_s1_data;
      assign DOV = r_s1_vld;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bsram_sp_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_bsram_sp_gen
// Description : Self-checking bench for bsram_sp_gen. Three instances share one
//               stimulus stream: A = 512 words / no-change / bypass,
//               B = 300 words / read-before-write / pipeline,
//               C = 300 words / write-through / bypass.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsram_sp_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CE, WRE, CLR;
  logic [13:0] AD;
  logic [35:0] DI;
  logic [3:0]  BE;

  logic [35:0] doA, doB, doC;
  logic        dovA, dovB, dovC;
  logic        busyA, busyB, busyC;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bsram_sp_gen dA (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WRE(WRE), .AD(AD), .DI(DI), .BE(BE),
    .CLR(CLR), .DO(doA), .DOV(dovA), .BUSY(busyA));

  bsram_sp_gen #(.DEPTH(300), .WRITE_MODE(2), .READ_MODE(1)) dB (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WRE(WRE), .AD(AD), .DI(DI), .BE(BE),
    .CLR(CLR), .DO(doB), .DOV(dovB), .BUSY(busyB));

  bsram_sp_gen #(.DEPTH(300), .WRITE_MODE(1), .READ_MODE(0)) dC (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WRE(WRE), .AD(AD), .DI(DI), .BE(BE),
    .CLR(CLR), .DO(doC), .DOV(dovC), .BUSY(busyC));

  typedef struct {
    logic        ce;
    logic        we;
    int          idx;
    logic [35:0] di;
    logic [3:0]  be;
    logic [35:0] a_do;
    logic        a_dov;
    logic [35:0] b_do;
    logic        b_dov;
    logic [35:0] c_do;
    logic        c_dov;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ce, input logic we, input int idx,
                     input logic [35:0] di, input logic [3:0] be,
                     input logic [35:0] a_do, input logic a_dov,
                     input logic [35:0] b_do, input logic b_dov,
                     input logic [35:0] c_do, input logic c_dov);
    vec_t v;
    v.ce = ce; v.we = we; v.idx = idx; v.di = di; v.be = be;
    v.a_do = a_do; v.a_dov = a_dov;
    v.b_do = b_do; v.b_dov = b_dov;
    v.c_do = c_do; v.c_dov = c_dov;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ce, input logic we, input int idx,
                       input logic [35:0] di, input logic [3:0] be);
    CE  = ce;
    WRE = we;
    AD  = 14'(idx << 5);
    DI  = di;
    BE  = be;
  endtask

  // Counts ticks until each instance drops BUSY; 0 means it never did
  task automatic sweep(input int wr_ticks, output int nA, output int nB,
                       output int nC, output int dov_seen);
    nA = 0; nB = 0; nC = 0; dov_seen = 0;
    for (int i = 1; i <= 700; i++) begin
      if (i <= wr_ticks) drive(1'b1, 1'b1, 5, 36'hFFFFFFFFF, 4'hF);
      else               drive(1'b0, 1'b0, 0, 36'h0, 4'h0);
      tick();
      if ((busyA && dovA) || (busyB && dovB) || (busyC && dovC)) dov_seen++;
      if (nA == 0 && !busyA) nA = i;
      if (nB == 0 && !busyB) nB = i;
      if (nC == 0 && !busyC) nC = i;
      if (nA != 0 && nB != 0 && nC != 0) break;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " A DO"},   doA,   36'h0);
    chk({tag, " A DOV"},  dovA,  1'b0);
    chk({tag, " A BUSY"}, busyA, 1'b1);
    chk({tag, " B DO"},   doB,   36'h0);
    chk({tag, " B DOV"},  dovB,  1'b0);
    chk({tag, " B BUSY"}, busyB, 1'b1);
    chk({tag, " C DO"},   doC,   36'h0);
    chk({tag, " C DOV"},  dovC,  1'b0);
    chk({tag, " C BUSY"}, busyC, 1'b1);
  endtask

  initial begin
    int nA, nB, nC, dseen;

    RESET = 1'b0;
    CLR   = 1'b0;
    drive(1'b0, 1'b0, 0, 36'h0, 4'h0);

    // reads 0/255/5/511 after the sweep, then functional traffic
    add(1,0,  0,36'h0,        4'hF, 36'h0,0, 36'h0,0, 36'h0,1);
    vq[0].a_dov = 1'b1;
    add(1,0,255,36'h0,        4'hF, 36'h0,1, 36'h0,1, 36'h0,1);
    add(1,0,  5,36'h0,        4'hF, 36'h0,1, 36'h0,1, 36'h0,1);
    add(1,0,511,36'h0,        4'hF, 36'h0,1, 36'h0,1, 36'h0,1);
    add(0,0,  0,36'h0,        4'h0, 36'h0,0, 36'h0,1, 36'h0,0);
    add(1,1,  1,36'h123456789,4'hF, 36'h0,0, 36'h0,0, 36'h123456789,1);
    add(1,0,  1,36'h0,        4'hF, 36'h123456789,1, 36'h0,1, 36'h123456789,1);
    add(1,1,  2,36'hFFFFFFFFF,4'h5, 36'h123456789,0, 36'h123456789,1, 36'h007FC01FF,1);
    add(1,0,  2,36'h0,        4'hF, 36'h007FC01FF,1, 36'h0,1, 36'h007FC01FF,1);
    add(1,1,  3,36'h555,      4'hF, 36'h007FC01FF,0, 36'h007FC01FF,1, 36'h555,1);
    add(1,1,  3,36'hAAA,      4'hF, 36'h007FC01FF,0, 36'h0,1, 36'hAAA,1);
    add(1,0,  3,36'h0,        4'hF, 36'hAAA,1, 36'h555,1, 36'hAAA,1);
    add(0,1,  3,36'hBAD,      4'hF, 36'hAAA,0, 36'hAAA,1, 36'hAAA,0);
    add(1,0,400,36'h0,        4'hF, 36'h0,1, 36'hAAA,0, 36'h0,1);
    add(1,1,400,36'h777,      4'hF, 36'h0,0, 36'h0,1, 36'h0,1);
    add(1,0,400,36'h0,        4'hF, 36'h777,1, 36'h0,1, 36'h0,1);
    add(1,0,100,36'h0,        4'hF, 36'h0,1, 36'h0,1, 36'h0,1);
    add(1,0,  1,36'h0,        4'hF, 36'h123456789,1, 36'h0,1, 36'h123456789,1);
    add(0,0,  0,36'h0,        4'h0, 36'h123456789,0, 36'h123456789,1, 36'h123456789,0);
    add(0,0,  0,36'h0,        4'h0, 36'h123456789,0, 36'h123456789,0, 36'h123456789,0);

    // Reset state
    tick(); tick();
    chk_reset_outputs("reset");

    // Release reset; writes attempted during the sweep must be ignored
    RESET = 1'b1;
    sweep(200, nA, nB, nC, dseen);
    chk("init sweep A cycles", 36'(nA), 36'd512);
    chk("init sweep B cycles", 36'(nB), 36'd300);
    chk("init sweep C cycles", 36'(nC), 36'd300);
    chk("init sweep DOV while busy", 36'(dseen), 36'd0);

    // Table-driven traffic, one access per cycle
    foreach (vq[k]) begin
      drive(vq[k].ce, vq[k].we, vq[k].idx, vq[k].di, vq[k].be);
      tick();
      chk($sformatf("vec%0d A DO", k),  doA,  vq[k].a_do);
      chk($sformatf("vec%0d A DOV", k), dovA, vq[k].a_dov);
      chk($sformatf("vec%0d B DO", k),  doB,  vq[k].b_do);
      chk($sformatf("vec%0d B DOV", k), dovB, vq[k].b_dov);
      chk($sformatf("vec%0d C DO", k),  doC,  vq[k].c_do);
      chk($sformatf("vec%0d C DOV", k), dovC, vq[k].c_dov);
      chk($sformatf("vec%0d A BUSY", k), busyA, 1'b0);
    end

    // CLR together with a write: CLR wins, no access, no DOV
    drive(1'b1, 1'b1, 1, 36'hFFFFFFFFF, 4'hF);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    drive(1'b0, 1'b0, 0, 36'h0, 4'h0);
    chk("clr+access A BUSY", busyA, 1'b1);
    chk("clr+access C BUSY", busyC, 1'b1);
    chk("clr+access C DOV",  dovC,  1'b0);
    chk("clr+access B DOV",  dovB,  1'b0);

    // CLR during a running sweep restarts it from word 0
    for (int i = 0; i < 49; i++) tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    sweep(0, nA, nB, nC, dseen);
    chk("restart sweep A cycles", 36'(nA), 36'd512);
    chk("restart sweep B cycles", 36'(nB), 36'd300);
    chk("restart sweep C cycles", 36'(nC), 36'd300);
    chk("DO holds through clear A", doA, 36'h123456789);
    chk("DO holds through clear B", doB, 36'h123456789);
    chk("DO holds through clear C", doC, 36'h123456789);

    // Reset in the middle of a sweep (pointer at 100)
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid-sweep A BUSY", busyA, 1'b1);
    chk("mid-sweep C BUSY", busyC, 1'b1);
    chk("mid-sweep A DO",   doA,   36'h123456789);
    RESET = 1'b0;
    #1;
    chk_reset_outputs("mid-sweep reset");
    tick(); tick();
    RESET = 1'b1;
    sweep(0, nA, nB, nC, dseen);
    chk("post-reset sweep A cycles", 36'(nA), 36'd512);
    chk("post-reset sweep B cycles", 36'(nB), 36'd300);
    chk("post-reset sweep C cycles", 36'(nC), 36'd300);

    // Array is zero again after the sweep
    drive(1'b1, 1'b0, 1, 36'h0, 4'h0);
    tick();
    chk("cleared idx1 A DO",  doA,  36'h0);
    chk("cleared idx1 A DOV", dovA, 1'b1);
    chk("cleared idx1 C DO",  doC,  36'h0);
    drive(1'b1, 1'b0, 3, 36'h0, 4'h0);
    tick();
    chk("cleared idx3 A DO", doA, 36'h0);
    chk("cleared idx1 B DO", doB, 36'h0);
    chk("cleared idx1 B DOV", dovB, 1'b1);
    drive(1'b0, 1'b0, 0, 36'h0, 4'h0);
    tick();
    chk("cleared idx3 B DO", doB, 36'h0);
    chk("idle A DOV", dovA, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
